// File: rtl/vga_sprite_layer_if.sv
// rtl/vga_sprite_layer_if.sv - sprite position request handshake bundle
//
// Purpose: carries a CPU position/enable request to the sprite layer.
// Signals:
//   pos_x, pos_y  requested sprite top-left coordinate
//   en_in         requested sprite enable, sampled with the position
//   pos_valid     request valid (held stable by the requester until transfer)
//   pos_ready     sprite layer pending buffer is empty
// Modports: master = requester (CPU side), slave = sprite layer.
interface vga_sprite_layer_if #(
  parameter int CRD_W = 10
);
  logic [CRD_W-1:0] pos_x;
  logic [CRD_W-1:0] pos_y;
  logic             en_in;
  logic             pos_valid;
  logic             pos_ready;

  modport master (
    output pos_x, pos_y, en_in, pos_valid,
    input  pos_ready
  );

  modport slave (
    input  pos_x, pos_y, en_in, pos_valid,
    output pos_ready
  );
endinterface

// File: rtl/vga_sprite_layer.sv
// rtl/vga_sprite_layer.sv - single-sprite RGB pixel layer with tear-free position updates
//
// Purpose: draws one SPR_W x SPR_H sprite from a bitmap ROM at a programmable
// position. Colour 0 is transparent. Output latency is 2 clocks from
// hcount/vcount to colour/hit.
// Ports:
//   clk, rst        pixel clock, asynchronous active-high reset
//   i_hcount/vcount current pixel coordinate from the timing generator
//   i_video_on      visible-area flag
//   i_frame_start   1-cycle pulse at first vblank line; applies pending position
//   pos_if          position request handshake (slave side)
//   o_rom_addr      row-major bitmap address
//   i_rom_data      bitmap pixel for the address presented one cycle earlier
//   o_colour_out    layer colour (0 = transparent)
//   o_hit           colour_out is a non-transparent sprite pixel
module vga_sprite_layer #(
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16,
  parameter int CRD_W    = 10,
  parameter int COLOUR_W = 12
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CRD_W-1:0]                   i_hcount,
  input  logic [CRD_W-1:0]                   i_vcount,
  input  logic                               i_video_on,
  input  logic                               i_frame_start,
  vga_sprite_layer_if.slave                  pos_if,
  output logic [$clog2(SPR_W*SPR_H)-1:0]     o_rom_addr,
  input  logic [COLOUR_W-1:0]                i_rom_data,
  output logic [COLOUR_W-1:0]                o_colour_out,
  output logic                               o_hit
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]       r_state;
  logic [CRD_W-1:0] r_pend_x;
  logic [CRD_W-1:0] r_pend_y;
  logic             r_pend_en;
  logic [CRD_W-1:0] r_act_x;
  logic [CRD_W-1:0] r_act_y;
  logic             r_act_en;
  logic             r_inside_d;

  logic             w_xfer;
  logic [CRD_W:0]   w_dx;
  logic [CRD_W:0]   w_dy;
  logic             w_inside;

  assign pos_if.pos_ready = (r_state == S_EMPTY);
  assign w_xfer = pos_if.pos_valid && (r_state == S_EMPTY);

  // One-entry pending buffer; the active registers only change on frame_start
  // so a frame is never drawn with a half-updated position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_EMPTY;
      r_pend_x  <= '0;
      r_pend_y  <= '0;
      r_pend_en <= 1'b0;
      r_act_x   <= '0;
      r_act_y   <= '0;
      r_act_en  <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          // A transfer coinciding with frame_start waits for the next frame.
          if (w_xfer) begin
            r_pend_x  <= pos_if.pos_x;
            r_pend_y  <= pos_if.pos_y;
            r_pend_en <= pos_if.en_in;
            r_state   <= S_FULL;
          end
        end
        S_FULL: begin
          if (i_frame_start) begin
            r_act_x  <= r_pend_x;
            r_act_y  <= r_pend_y;
            r_act_en <= r_pend_en;
            r_state  <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  // One extra bit keeps pixels left/above the sprite negative (MSB set), so
  // they compare as out of range instead of wrapping into the sprite.
  assign w_dx = {1'b0, i_hcount} - {1'b0, r_act_x};
  assign w_dy = {1'b0, i_vcount} - {1'b0, r_act_y};
  assign w_inside = r_act_en && i_video_on &&
                    (w_dx < (CRD_W+1)'(SPR_W)) && (w_dy < (CRD_W+1)'(SPR_H));

  // Stage 0: address the ROM; address holds outside the sprite to avoid
  // needless ROM toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rom_addr <= '0;
      r_inside_d <= 1'b0;
    end else begin
      if (w_inside) begin
        o_rom_addr <= {w_dy[YW-1:0], w_dx[XW-1:0]};
      end
      r_inside_d <= w_inside;
    end
  end

  // Stage 1: gate ROM data with the delayed inside flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_colour_out <= '0;
      o_hit        <= 1'b0;
    end else begin
      o_colour_out <= r_inside_d ? i_rom_data : '0;
      o_hit        <= r_inside_d && (i_rom_data != '0);
    end
  end

endmodule
